// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_PREP,
        DIV_ITER,
        DZ
    } muldiv_state_t;

    // One prep cycle followed by 32 restoring iterations.
    localparam int DIV_BUSY_CYCLES = 33;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Issue-side bus between execute and the HI/LO multiply/divide controller.
interface hilo_muldiv_ctrl_if;
    import muldiv_pkg::*;

    logic        start_valid;
    muldiv_op_t  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;

    modport master (output start_valid, op, src_a, src_b, input busy, done);
    modport slave  (input start_valid, op, src_a, src_b, output busy, done);

endinterface

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider core; sign handling and sequencing live in the controller.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_step,
    output logic [31:0] rem_step
);

    logic [31:0] div_q;
    logic [31:0] quo_q;
    logic [32:0] rem_q;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [32:0] rem_next;
    logic [31:0] quo_next;

    // Bit 32 of the trial difference is set exactly when the shifted remainder is below the divisor.
    always_comb begin
        rem_shift = (rem_q << 1) | {32'd0, quo_q[31]};
        diff      = rem_shift - {1'b0, div_q};
        rem_next  = rem_shift;
        quo_next  = {quo_q[30:0], 1'b0};
        if (!diff[32]) begin
            rem_next = diff;
            quo_next = {quo_q[30:0], 1'b1};
        end
    end

    assign quo_step = quo_next;
    assign rem_step = rem_next[31:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else if (load) begin
            div_q <= divisor;
            quo_q <= dividend;
            rem_q <= '0;
        end else if (step) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Owns HI/LO, sequences multi-cycle MULT/MULTU/DIV/DIVU and arbitrates MTHI/MTLO writes.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_ITERS = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    hilo_muldiv_ctrl_if.slave    bus,
    input  logic                 flush,
    input  logic                 hi_writeW,
    input  logic                 lo_writeW,
    input  logic [31:0]          wdataW,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    muldiv_state_t state;
    muldiv_state_t state_next;
    logic [5:0]    cnt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    muldiv_op_t    op_q;
    logic [63:0]   product_q;

    logic          accept;
    logic          start_is_div;
    logic          start_signed;
    logic [63:0]   mul_a;
    logic [63:0]   mul_b;
    logic          div_signed;
    logic          neg_a;
    logic          neg_b;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic          core_load;
    logic          core_step;
    logic [31:0]   quo_step;
    logic [31:0]   rem_step;
    logic          complete;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    assign accept       = (state == IDLE) && bus.start_valid && !flush;
    assign start_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign start_signed = (bus.op == OP_MULT);
    assign mul_a        = {{32{start_signed & bus.src_a[31]}}, bus.src_a};
    assign mul_b        = {{32{start_signed & bus.src_b[31]}}, bus.src_b};

    assign div_signed = (op_q == OP_DIV);
    assign neg_a      = div_signed & a_q[31];
    assign neg_b      = div_signed & b_q[31];
    assign abs_a      = neg_a ? -a_q : a_q;
    assign abs_b      = neg_b ? -b_q : b_q;

    div_iter u_div_iter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (core_load),
        .step     (core_step),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quo_step (quo_step),
        .rem_step (rem_step)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A flush while busy abandons the operation, including one that would complete this edge.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;
        res_hi     = '0;
        res_lo     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!start_is_div) begin
                        state_next = MUL;
                    end else if (bus.src_b == 32'd0) begin
                        state_next = DZ;
                    end else begin
                        state_next = DIV_PREP;
                    end
                end
            end
            MUL: begin
                if (cnt == MUL_LAST) begin
                    complete   = 1'b1;
                    res_hi     = product_q[63:32];
                    res_lo     = product_q[31:0];
                    state_next = IDLE;
                end
            end
            DIV_PREP: begin
                core_load  = 1'b1;
                state_next = DIV_ITER;
            end
            DIV_ITER: begin
                core_step = 1'b1;
                if (cnt == DIV_LAST) begin
                    complete   = 1'b1;
                    res_hi     = neg_a ? -rem_step : rem_step;
                    res_lo     = (neg_a ^ neg_b) ? -quo_step : quo_step;
                    state_next = IDLE;
                end
            end
            DZ: begin
                complete   = 1'b1;
                res_hi     = a_q;
                res_lo     = 32'hFFFF_FFFF;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush && (state != IDLE)) begin
            state_next = IDLE;
            complete   = 1'b0;
            core_load  = 1'b0;
            core_step  = 1'b0;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = complete;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if ((state_next == state) && ((state == MUL) || (state == DIV_ITER))) begin
            cnt <= cnt + 6'd1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_MULT;
            product_q <= '0;
        end else if (accept) begin
            a_q       <= bus.src_a;
            b_q       <= bus.src_b;
            op_q      <= bus.op;
            product_q <= mul_a * mul_b;
        end
    end

    // Completion beats a same-edge MTHI/MTLO: the retiring move is older than the mul/div.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (complete) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (hi_writeW) hi <= wdataW;
            if (lo_writeW) lo <= wdataW;
        end
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Owns the architectural HI/LO register pair.
- Sequences multi-cycle MULT/MULTU/DIV/DIVU operations issued from execute.
- Arbitrates HI/LO writes between operation completion and MTHI/MTLO retiring in writeback.
- Asserts busy so the hazard unit stalls younger MFHI/MFLO/mul/div instructions.

Parameters:
- MUL_LAT, 3, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_ITERS, 32, radix-2 restoring iterations for DIV/DIVU (fixed 32 for 32-bit operands)

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- start_valid  input  1  mul/div instruction in execute requests start
- op  input  2  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3
- src_a  input  32  rs operand (dividend / multiplicand)
- src_b  input  32  rt operand (divisor / multiplier)
- flush  input  1  pipeline flush (exception/eret); aborts in-flight operation
- hi_writeW  input  1  MTHI retiring in writeback
- lo_writeW  input  1  MTLO retiring in writeback
- wdataW  input  32  MTHI/MTLO data
- busy  output  1  operation in flight; hazard unit stalls on it
- done  output  1  one-cycle pulse, HI/LO updated by completion this edge
- hi  output  32  current HI
- lo  output  32  current LO

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low on `resetn`. Reset gives state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Start acceptance:
  - Accepted at edge T when state=IDLE, start_valid=1, flush=0.
  - Operands and op are latched at T.
  - start_valid while busy is ignored; the hazard unit guarantees it is held.
- States:
  - IDLE -> MUL (op MULT/MULTU) or DIV (op DIV/DIVU) on accept.
  - MUL: count MUL_LAT cycles, then write {hi,lo}=product, return to IDLE.
  - DIV: 1 prep cycle (abs values, sign capture), then DIV_ITERS iteration cycles; the final iteration edge writes hi=remainder, lo=quotient, return to IDLE.
  - Divisor==0 detected at accept: DZ state, 1 cycle, writes lo=32'hFFFF_FFFF, hi=src_a.
- Latency:
  - busy is high cycles T+1..T+N, with N = MUL_LAT (mul), 33 (div), 1 (div-by-zero).
  - The HI/LO write and the done pulse occur on the edge ending cycle T+N.
  - New values are visible at T+N+1, when busy=0.
- Arithmetic:
  - MULT is a signed 32x32->64 product; MULTU is unsigned.
  - DIV runs an unsigned core on |a|,|b|. Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a.
  - 0x8000_0000 / -1 yields lo=0x8000_0000, hi=0 with no trap.
  - All intermediates are 33 bits wide in the divider; the remainder register is 33 bits.
- MTHI/MTLO: hi_writeW/lo_writeW update hi/lo at the next edge in any state.
- Simultaneous events:
  - Completion and MTHI/MTLO on the same edge: completion wins for both registers. The retiring MT is older, because busy blocks younger instructions.
  - Start and MT on the same edge in IDLE: the MT applies now; completion overwrites later.
  - flush in any busy state: return to IDLE next edge, hi/lo unchanged, no done pulse.
  - flush coincident with start_valid: the start is not accepted.
  - flush does not block an MT write on the same edge.
- Reset asserted mid-operation: immediate return to the reset values; no partial write.

Decomposition:
- Package `muldiv_pkg`:
  - muldiv_op_t enum
  - muldiv_state_t enum {IDLE, MUL, DIV_PREP, DIV_ITER, DZ}
  - DIV_BUSY_CYCLES=33 constant
- Sub-module `div_iter`:
  - Unsigned radix-2 restoring divider core: load, step, quotient/remainder out.
  - The controller owns the sign handling and sequencing.
- The multiplier is an inferred product registered at accept; the MUL_LAT counter only models pipeline latency.

Test Plan:
- MULT a=0xFFFF_FFFE(-2) b=3 → busy 3 cycles, done pulse, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands → hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV a=-7 b=2 → busy exactly 33 cycles, lo=0xFFFF_FFFD(-3), hi=0xFFFF_FFFF(-1). DIVU a=100 b=7 → lo=14, hi=2.
- DIV a=0x8000_0000 b=0xFFFF_FFFF → lo=0x8000_0000, hi=0. DIVU a=5 b=0 → busy 1 cycle, lo=0xFFFF_FFFF, hi=5.
- MTHI 0x1234 at the same edge as MULT 2*3 completion → hi=0, lo=6 (completion wins). MTLO 0xAA while IDLE → lo=0xAA next cycle.
- DIV started, flush at cycle 10 of busy → busy=0 next cycle, no done, hi/lo hold prior values. A new MULT then completes correctly.
- resetn dropped mid-DIV (asynchronously, between edges) → hi=lo=0 and busy=0 immediately. start_valid pulsed while busy is ignored, and the result matches the first operation.
